exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Control FSM wrapped around the execute datapath. Accepts one decoded instruction per
//  handshake and sequences its side effects:
//   - register writeback
//   - CPSR (nzcv) update
//   - PC redirect with flush
//   - multi-cycle ld/str handshake to data memory
//  Owns the architectural CPSR that feeds the condition checker. Sits between execute and memory/writeback.
// PARAMETERS
//  DATA_W     32   datapath width
//  ADDR_W     22   data-memory address width (md field width)
//  LINK_REG   15   register written with the return address by call
//  TIMEOUT    255  max cycles mem_req may wait for mem_ack before abort (1..255)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  reset_n       in   1       synchronous reset, active low
//  in_valid      in   1       decoded instruction present
//  in_ready      out  1       sequencer can accept (IDLE only)
//  is_alu_op/is_cmp_op/is_jmp_op/is_ld_op/is_str_op/is_call_op/is_ret_op  in 1 each  op class
//  taken         in   1       branch condition result (jmp only)
//  nzcv_in       in   4       comparator flags
//  alu_result    in   DATA_W  ALU output
//  rd_num        in   4       destination/source register number
//  rd_val        in   DATA_W  store data (str) / return target (ret)
//  md_val        in   DATA_W  sign-extended md: jump/call target, memory address
//  pc_next       in   DATA_W  address of following instruction (call link value)
//  mem_req       out  1       memory request, held until ack or timeout
//  mem_we        out  1       1=store, 0=load; valid while mem_req
//  mem_addr      out  ADDR_W  md_val[ADDR_W-1:0], stable while mem_req
//  mem_wdata     out  DATA_W  rd_val captured at accept
//  mem_ack       in   1       completion; ignored unless mem_req=1
//  mem_rdata     in   DATA_W  load data, valid with mem_ack
//  wb_en         out  1       register write pulse
//  wb_num        out  4       register number
//  wb_val        out  DATA_W  write data
//  pc_we         out  1       PC redirect pulse
//  pc_val        out  DATA_W  new PC
//  flush         out  1       kill younger stages; equals pc_we
//  cpsr_out      out  32      {28'd0, nzcv}
//  mem_err       out  1       one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset (reset_n low at edge): state=IDLE.
//    - All pulse outputs 0.
//    - mem_req=0; mem_we=0; mem_addr/mem_wdata/wb_num/wb_val/pc_val=0.
//    - cpsr=0; timeout counter=0.
//    - A request in flight is dropped with no writeback. in_ready=1 from the first cycle after reset.
//  - States:
//    - IDLE: in_ready=1.
//    - MEM: in_ready=0, mem_req=1.
//  - Accept at edge T when in_valid & in_ready. If several op flags are set, priority is ld>str>call>ret>jmp>cmp>alu.
//    No flag set = NOP: accepted, no effect.
//  - Single-cycle ops; effects are registered and visible in cycle T+1 as 1-cycle pulses; stay in IDLE:
//    - alu:  wb_en, wb_num=rd_num, wb_val=alu_result.
//    - cmp:  cpsr[3:0]<=nzcv_in, visible on cpsr_out at T+1. No wb.
//    - jmp:  if taken, pc_we=flush=1, pc_val=md_val; otherwise nothing.
//    - call: pc_we=flush=1, pc_val=md_val. Also wb_en, wb_num=LINK_REG, wb_val=pc_next, in the same cycle.
//    - ret:  pc_we=flush=1, pc_val=rd_val.
//  - ld/str:
//    - At accept, capture addr, we, wdata and rd_num; go to MEM. mem_req=1 from T+1.
//    - In MEM, mem_ack sampled 1 at edge A:
//      - mem_req=0 from A+1; state=IDLE.
//      - ld: wb_en pulse at A+1 with wb_val=mem_rdata captured at A and wb_num=captured rd_num.
//      - str: no wb.
//      - in_ready=1 at A+1. Minimum ld/str occupancy is 2 cycles: ack in the first req cycle.
//    - Timeout counter clears on entry to MEM and increments each MEM cycle without ack.
//      When it reaches TIMEOUT and no ack arrives:
//      - mem_req=0 next cycle, mem_err pulse, no wb, return to IDLE.
//      - An ack on the same edge as the timeout wins: normal completion.
//  - mem_ack outside MEM is ignored. cpsr changes only on cmp or reset.
//  - At most one of pc_we/mem_err per cycle. wb_en and pc_we coincide only for call.
// TESTING
//  1. alu: rd_num=3, alu_result=0x1234 accepted at T -> wb_en=1, wb_num=3, wb_val=0x1234 at T+1 only.
//  2. cmp nzcv_in=4'b0110, then jmp taken md_val=0x40 -> cpsr_out=0x6 after the cmp; pc_we=flush=1, pc_val=0x40.
//     Repeat with taken=0 -> no pc_we.
//  3. ld md_val=0x10, rd_num=5, mem_ack after 3 req cycles with rdata=0xCAFEF00D:
//     -> mem_req high exactly 3 cycles, addr stable 0x10, in_ready low throughout;
//        wb r5=0xCAFEF00D on the cycle after ack.
//  4. str rd_val=0xA5A5 with ack in the first req cycle -> mem_we=1, mem_wdata=0xA5A5, no wb_en;
//     next in_valid accepted 2 cycles after the first.
//  5. call md_val=0x80, pc_next=0x21 -> same cycle: pc_val=0x80, wb r15=0x21, flush=1.
//     ret rd_val=0x21 -> pc_val=0x21.
//  6. ld with no ack, TIMEOUT=4 -> mem_err pulse, no wb, in_ready returns.
//     Separately, reset_n low during MEM -> mem_req=0 next cycle, no wb, cpsr=0.

Source files
------------

// File: rtl/exec_sequencer.sv
// Execute-stage control sequencer: registers writeback, CPSR, PC-redirect and
// data-memory handshake side effects for one decoded instruction at a time.
module exec_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 22,
    parameter int unsigned LINK_REG = 15,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_alu_op,
    input  logic              is_cmp_op,
    input  logic              is_jmp_op,
    input  logic              is_ld_op,
    input  logic              is_str_op,
    input  logic              is_call_op,
    input  logic              is_ret_op,
    input  logic              taken,
    input  logic [3:0]        nzcv_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        rd_num,
    input  logic [DATA_W-1:0] rd_val,
    input  logic [DATA_W-1:0] md_val,
    input  logic [DATA_W-1:0] pc_next,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [3:0]        wb_num,
    output logic [DATA_W-1:0] wb_val,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_val,
    output logic              flush,
    output logic [31:0]       cpsr_out,
    output logic              mem_err
);

    typedef enum logic [0:0] {StIdle, StMem} state_e;

    // Last wait-count value before an unacknowledged request is abandoned.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e     state;
    logic [3:0] cpsr;
    logic [3:0] mem_rd;
    logic [7:0] tmo_cnt;

    assign in_ready = (state == StIdle);
    assign cpsr_out = {28'd0, cpsr};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= StIdle;
            cpsr      <= 4'd0;
            mem_rd    <= 4'd0;
            tmo_cnt   <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_en     <= 1'b0;
            wb_num    <= 4'd0;
            wb_val    <= '0;
            pc_we     <= 1'b0;
            pc_val    <= '0;
            flush     <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            wb_en   <= 1'b0;
            pc_we   <= 1'b0;
            flush   <= 1'b0;
            mem_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        if (is_ld_op || is_str_op) begin
                            state     <= StMem;
                            mem_req   <= 1'b1;
                            mem_we    <= ~is_ld_op;
                            mem_addr  <= md_val[ADDR_W-1:0];
                            mem_wdata <= rd_val;
                            mem_rd    <= rd_num;
                            tmo_cnt   <= 8'd0;
                        end else if (is_call_op) begin
                            pc_we  <= 1'b1;
                            flush  <= 1'b1;
                            pc_val <= md_val;
                            wb_en  <= 1'b1;
                            wb_num <= 4'(LINK_REG);
                            wb_val <= pc_next;
                        end else if (is_ret_op) begin
                            pc_we  <= 1'b1;
                            flush  <= 1'b1;
                            pc_val <= rd_val;
                        end else if (is_jmp_op) begin
                            if (taken) begin
                                pc_we  <= 1'b1;
                                flush  <= 1'b1;
                                pc_val <= md_val;
                            end
                        end else if (is_cmp_op) begin
                            cpsr <= nzcv_in;
                        end else if (is_alu_op) begin
                            wb_en  <= 1'b1;
                            wb_num <= rd_num;
                            wb_val <= alu_result;
                        end
                    end
                end
                StMem: begin
                    // An ack arriving on the timeout edge still completes normally.
                    if (mem_ack) begin
                        state   <= StIdle;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            wb_en  <= 1'b1;
                            wb_num <= mem_rd;
                            wb_val <= mem_rdata;
                        end
                    end else if (tmo_cnt == TmoLast) begin
                        state   <= StIdle;
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios plus a randomized
// transaction-level reference model.
module tb_exec_sequencer;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic        is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op, is_call_op, is_ret_op;
    logic        taken;
    logic [3:0]  nzcv_in, rd_num, wb_num;
    logic [31:0] alu_result, rd_val, md_val, pc_next, mem_wdata, mem_rdata, wb_val, pc_val;
    logic [31:0] cpsr_out;
    logic [21:0] mem_addr;
    logic        mem_req, mem_we, mem_ack, wb_en, pc_we, flush, mem_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] exp_cpsr = 4'd0;

    exec_sequencer #(.DATA_W(32), .ADDR_W(22), .LINK_REG(15), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_alu_op(is_alu_op), .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op),
        .is_ld_op(is_ld_op), .is_str_op(is_str_op), .is_call_op(is_call_op),
        .is_ret_op(is_ret_op), .taken(taken), .nzcv_in(nzcv_in), .alu_result(alu_result),
        .rd_num(rd_num), .rd_val(rd_val), .md_val(md_val), .pc_next(pc_next),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_num(wb_num),
        .wb_val(wb_val), .pc_we(pc_we), .pc_val(pc_val), .flush(flush),
        .cpsr_out(cpsr_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Flag order, high to low priority: ld str call ret jmp cmp alu.
    task automatic set_flags(input logic [6:0] f);
        {is_ld_op, is_str_op, is_call_op, is_ret_op, is_jmp_op, is_cmp_op, is_alu_op} = f;
    endtask

    task automatic clear_inputs;
        in_valid = 1'b0; set_flags(7'd0); taken = 1'b0; nzcv_in = 4'd0;
        alu_result = '0; rd_num = 4'd0; rd_val = '0; md_val = '0; pc_next = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        clear_inputs(); reset_n = 1'b0;
        step(); step();
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %0b exp 0", mem_req); end
        n_tests++; if ({wb_en, pc_we, flush, mem_err} !== 4'b0) begin n_fail++; $display("FAIL rst_pulses got %b exp 0000", {wb_en, pc_we, flush, mem_err}); end
        n_tests++; if ({mem_addr, mem_wdata, wb_num, wb_val, pc_val} !== '0) begin n_fail++; $display("FAIL rst_data got nonzero exp 0"); end
        n_tests++; if (cpsr_out !== 32'd0) begin n_fail++; $display("FAIL rst_cpsr got %h exp 0", cpsr_out); end
        reset_n = 1'b1; step();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
        exp_cpsr = 4'd0;
    endtask

    task automatic test_alu;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b0000001); rd_num = 4'd3; alu_result = 32'h1234;
        step(); clear_inputs();
        n_tests++; if ({wb_en, wb_num, wb_val} !== {1'b1, 4'd3, 32'h1234}) begin n_fail++; $display("FAIL alu_wb got %0b/%0d/%h exp 1/3/1234", wb_en, wb_num, wb_val); end
        n_tests++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL alu_pc_we got %0b exp 0", pc_we); end
        step();
        n_tests++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL alu_wb_pulse got %0b exp 0", wb_en); end
    endtask

    task automatic test_cmp_jmp;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b0000010); nzcv_in = 4'b0110;
        step(); clear_inputs(); exp_cpsr = 4'b0110;
        n_tests++; if (cpsr_out !== 32'h6) begin n_fail++; $display("FAIL cmp_cpsr got %h exp 6", cpsr_out); end
        n_tests++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL cmp_no_wb got %0b exp 0", wb_en); end
        in_valid = 1'b1; set_flags(7'b0000100); taken = 1'b1; md_val = 32'h40;
        step(); clear_inputs();
        n_tests++; if ({pc_we, flush, pc_val} !== {2'b11, 32'h40}) begin n_fail++; $display("FAIL jmp_taken got %0b%0b/%h exp 11/40", pc_we, flush, pc_val); end
        n_tests++; if (cpsr_out !== 32'h6) begin n_fail++; $display("FAIL jmp_cpsr got %h exp 6", cpsr_out); end
        in_valid = 1'b1; set_flags(7'b0000100); taken = 1'b0; md_val = 32'h80;
        step(); clear_inputs();
        n_tests++; if ({pc_we, flush} !== 2'b00) begin n_fail++; $display("FAIL jmp_not_taken got %0b%0b exp 00", pc_we, flush); end
    endtask

    task automatic test_ld;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b1000000); md_val = 32'h10; rd_num = 4'd5;
        step(); clear_inputs();
        for (int k = 1; k <= 3; k++) begin
            n_tests++; if ({mem_req, in_ready, mem_we, mem_addr} !== {3'b100, 22'h10}) begin n_fail++; $display("FAIL ld_req_c%0d got req=%0b rdy=%0b we=%0b addr=%h exp 1/0/0/10", k, mem_req, in_ready, mem_we, mem_addr); end
            if (k == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; end
            step();
        end
        mem_ack = 1'b0;
        n_tests++; if ({mem_req, in_ready} !== 2'b01) begin n_fail++; $display("FAIL ld_done got req=%0b rdy=%0b exp 0/1", mem_req, in_ready); end
        n_tests++; if ({wb_en, wb_num, wb_val} !== {1'b1, 4'd5, 32'hCAFEF00D}) begin n_fail++; $display("FAIL ld_wb got %0b/%0d/%h exp 1/5/cafef00d", wb_en, wb_num, wb_val); end
    endtask

    task automatic test_str;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b0100000); rd_val = 32'hA5A5; md_val = 32'h24;
        step(); clear_inputs();
        n_tests++; if ({mem_req, mem_we, in_ready, mem_wdata} !== {3'b110, 32'hA5A5}) begin n_fail++; $display("FAIL str_req got req=%0b we=%0b rdy=%0b wd=%h exp 1/1/0/a5a5", mem_req, mem_we, in_ready, mem_wdata); end
        mem_ack = 1'b1; mem_rdata = 32'h5555;
        step(); mem_ack = 1'b0;
        n_tests++; if ({wb_en, mem_req, in_ready} !== 3'b001) begin n_fail++; $display("FAIL str_done got wb=%0b req=%0b rdy=%0b exp 0/0/1", wb_en, mem_req, in_ready); end
        in_valid = 1'b1; set_flags(7'b0000001); rd_num = 4'd7; alu_result = 32'h77;
        step(); clear_inputs();
        n_tests++; if ({wb_en, wb_num, wb_val} !== {1'b1, 4'd7, 32'h77}) begin n_fail++; $display("FAIL str_next_accept got %0b/%0d/%h exp 1/7/77", wb_en, wb_num, wb_val); end
    endtask

    task automatic test_call_ret;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b0010000); md_val = 32'h80; pc_next = 32'h21;
        step(); clear_inputs();
        n_tests++; if ({pc_we, flush, pc_val} !== {2'b11, 32'h80}) begin n_fail++; $display("FAIL call_pc got %0b%0b/%h exp 11/80", pc_we, flush, pc_val); end
        n_tests++; if ({wb_en, wb_num, wb_val} !== {1'b1, 4'd15, 32'h21}) begin n_fail++; $display("FAIL call_link got %0b/%0d/%h exp 1/15/21", wb_en, wb_num, wb_val); end
        in_valid = 1'b1; set_flags(7'b0001000); rd_val = 32'h21; md_val = 32'h99;
        step(); clear_inputs();
        n_tests++; if ({pc_we, flush, pc_val, wb_en} !== {2'b11, 32'h21, 1'b0}) begin n_fail++; $display("FAIL ret_pc got %0b%0b/%h wb=%0b exp 11/21 wb=0", pc_we, flush, pc_val, wb_en); end
    endtask

    task automatic test_timeout;
        int cycles;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b1000000); md_val = 32'h33; rd_num = 4'd9;
        step(); clear_inputs();
        cycles = 0;
        while (mem_req === 1'b1 && cycles < 10) begin cycles++; step(); end
        n_tests++; if (cycles != TMO) begin n_fail++; $display("FAIL tmo_req_cycles got %0d exp %0d", cycles, TMO); end
        n_tests++; if ({mem_err, wb_en, in_ready, pc_we} !== 4'b1010) begin n_fail++; $display("FAIL tmo_abort got err=%0b wb=%0b rdy=%0b pc=%0b exp 1/0/1/0", mem_err, wb_en, in_ready, pc_we); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        step(); mem_ack = 1'b0;
        n_tests++; if ({mem_err, wb_en, mem_req} !== 3'b000) begin n_fail++; $display("FAIL tmo_stray_ack got err=%0b wb=%0b req=%0b exp 000", mem_err, wb_en, mem_req); end
    endtask

    task automatic test_back_to_back;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b0000001); rd_num = 4'd2; alu_result = 32'hBEEF;
        step();
        set_flags(7'b0000010); nzcv_in = 4'b1001;
        n_tests++; if ({wb_en, wb_val} !== {1'b1, 32'hBEEF}) begin n_fail++; $display("FAIL b2b_alu got %0b/%h exp 1/beef", wb_en, wb_val); end
        step(); clear_inputs(); exp_cpsr = 4'b1001;
        n_tests++; if ({wb_en, cpsr_out} !== {1'b0, 32'h9}) begin n_fail++; $display("FAIL b2b_cmp got wb=%0b cpsr=%h exp 0/9", wb_en, cpsr_out); end
    endtask

    task automatic test_reset_mem;
        clear_inputs(); in_valid = 1'b1; set_flags(7'b0000010); nzcv_in = 4'hF;
        step(); clear_inputs();
        in_valid = 1'b1; set_flags(7'b1000000); md_val = 32'h50; rd_num = 4'd4;
        step(); clear_inputs(); step();
        reset_n = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111;
        step(); mem_ack = 1'b0; exp_cpsr = 4'd0;
        n_tests++; if ({mem_req, wb_en, cpsr_out} !== {2'b00, 32'd0}) begin n_fail++; $display("FAIL rstmem got req=%0b wb=%0b cpsr=%h exp 0/0/0", mem_req, wb_en, cpsr_out); end
        reset_n = 1'b1; step();
        n_tests++; if ({mem_req, wb_en, in_ready} !== 3'b001) begin n_fail++; $display("FAIL rstmem_after got req=%0b wb=%0b rdy=%0b exp 0/0/1", mem_req, wb_en, in_ready); end
    endtask

    // Reference model: decode class by priority, then predict the transaction outcome.
    task automatic test_random;
        logic [6:0] f; int c, cls, d, nreq;
        logic [31:0] a, r, m, p, rv; logic [3:0] rn, nz; logic tk;
        logic e_wb, e_pc; logic [3:0] e_num; logic [31:0] e_val, e_pcv;
        for (int it = 0; it < 200; it++) begin
            c = $urandom_range(0, 7);
            if (c == 7) f = 7'd0;
            else f = (7'd1 << c) | (7'($urandom) & ((7'd1 << c) - 7'd1));
            cls = -1;
            for (int b = 0; b < 7; b++) if (f[b]) cls = b;
            a = $urandom; r = $urandom; m = $urandom; p = $urandom; rv = $urandom;
            rn = 4'($urandom); nz = 4'($urandom); tk = 1'($urandom); d = $urandom_range(1, 6);
            clear_inputs(); in_valid = 1'b1; set_flags(f); alu_result = a; md_val = m;
            pc_next = p; rd_val = rv; rd_num = rn; nzcv_in = nz; taken = tk;
            mem_ack = 1'($urandom);
            step(); clear_inputs();
            if (cls == 6 || cls == 5) begin
                nreq = (d <= TMO) ? d : TMO;
                for (int k = 1; k <= nreq; k++) begin
                    n_tests++; if ({mem_req, in_ready, mem_we, mem_addr} !== {2'b10, cls == 5, m[21:0]}) begin n_fail++; $display("FAIL rnd%0d_req c%0d got req=%0b rdy=%0b we=%0b addr=%h exp 1/0/%0b/%h", it, k, mem_req, in_ready, mem_we, mem_addr, cls == 5, m[21:0]); end
                    if (cls == 5) begin n_tests++; if (mem_wdata !== rv) begin n_fail++; $display("FAIL rnd%0d_wdata got %h exp %h", it, mem_wdata, rv); end end
                    if (k == d) begin mem_ack = 1'b1; mem_rdata = r; end
                    step(); mem_ack = 1'b0;
                end
                e_wb = (cls == 6) && (d <= TMO);
                n_tests++; if ({mem_req, in_ready, wb_en, mem_err, pc_we} !== {2'b01, e_wb, d > TMO, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_mem_end got req=%0b rdy=%0b wb=%0b err=%0b pc=%0b exp 0/1/%0b/%0b/0", it, mem_req, in_ready, wb_en, mem_err, pc_we, e_wb, d > TMO); end
                if (e_wb) begin n_tests++; if ({wb_num, wb_val} !== {rn, r}) begin n_fail++; $display("FAIL rnd%0d_ld_wb got %0d/%h exp %0d/%h", it, wb_num, wb_val, rn, r); end end
            end else begin
                if (cls == 1) exp_cpsr = nz;
                e_wb  = (cls == 0) || (cls == 4);
                e_num = (cls == 4) ? 4'd15 : rn;
                e_val = (cls == 4) ? p : a;
                e_pc  = (cls == 4) || (cls == 3) || (cls == 2 && tk);
                e_pcv = (cls == 3) ? rv : m;
                n_tests++; if ({wb_en, pc_we, flush, mem_req, mem_err, in_ready} !== {e_wb, e_pc, e_pc, 3'b001}) begin n_fail++; $display("FAIL rnd%0d_ctl cls=%0d got wb=%0b pc=%0b fl=%0b req=%0b err=%0b rdy=%0b exp %0b/%0b/%0b/0/0/1", it, cls, wb_en, pc_we, flush, mem_req, mem_err, in_ready, e_wb, e_pc, e_pc); end
                if (e_wb) begin n_tests++; if ({wb_num, wb_val} !== {e_num, e_val}) begin n_fail++; $display("FAIL rnd%0d_wb got %0d/%h exp %0d/%h", it, wb_num, wb_val, e_num, e_val); end end
                if (e_pc) begin n_tests++; if (pc_val !== e_pcv) begin n_fail++; $display("FAIL rnd%0d_pcval got %h exp %h", it, pc_val, e_pcv); end end
            end
            n_tests++; if (cpsr_out !== {28'd0, exp_cpsr}) begin n_fail++; $display("FAIL rnd%0d_cpsr got %h exp %h", it, cpsr_out, exp_cpsr); end
            mem_ack = 1'($urandom);
            step(); mem_ack = 1'b0;
            n_tests++; if ({wb_en, pc_we, mem_err, mem_req} !== 4'b0000) begin n_fail++; $display("FAIL rnd%0d_idle got wb=%0b pc=%0b err=%0b req=%0b exp 0000", it, wb_en, pc_we, mem_err, mem_req); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_cmp_jmp();
        test_ld();
        test_str();
        test_call_ret();
        test_timeout();
        test_back_to_back();
        test_reset_mem();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
